// File: rtl/mul_share_arbiter.sv
// Shares one unsigned WIDTH x WIDTH array multiplier between two requesters.
// Round-robin grant in IDLE, programmable settle delay in CALC, held response in DONE.
module mul_share_arbiter #(
   parameter int WIDTH      = 4,
   parameter int MUL_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               req1_ready,
   output logic               rsp_valid,
   output logic [2*WIDTH-1:0] rsp_data,
   output logic               rsp_id,
   input  logic               rsp_ready,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int            CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_id;
   logic [CW-1:0]      r_cnt;
   logic               r_last;
   logic               r_rsp_valid;
   logic [2*WIDTH-1:0] r_rsp_data;
   logic               r_rsp_id;

   logic               w_idle;
   logic               w_gnt1;
   logic               w_hs;
   logic [2*WIDTH-1:0] w_prod;

   assign w_idle = (r_state == S_IDLE);
   // On a tie, requester 1 wins only when requester 0 was served last.
   assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
   assign w_hs   = w_idle & (req0_valid | req1_valid);

   assign req0_ready = w_idle & req0_valid & ~w_gnt1;
   assign req1_ready = w_idle & w_gnt1;

   assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign busy      = ~w_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_id        <= 1'b0;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_a     <= w_gnt1 ? req1_a : req0_a;
                  r_b     <= w_gnt1 ? req1_b : req0_b;
                  r_id    <= w_gnt1;
                  r_last  <= w_gnt1;
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               // Product is captured only once the array has had MUL_CYCLES cycles to settle.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_rsp_data  <= w_prod;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
